// File: rtl/switch_debouncer_if.sv
// -----------------------------------------------------------------------------
// switch_debouncer_if
// Bundles the switch-side and Moore-machine-side signals of switch_debouncer.
//   w_raw    [1:0] : raw switch bus, asynchronous to the debouncer clock
//   w_stable [1:0] : debounced switch code (drives Moore machine W)
//   w_change       : one-cycle strobe when w_stable takes a new value
//   busy           : a candidate value is currently settling
// Modports:
//   master : environment side (drives w_raw, observes the results)
//   slave  : debouncer side (reads w_raw, drives the results)
// -----------------------------------------------------------------------------
interface switch_debouncer_if;
    logic [1:0] w_raw;
    logic [1:0] w_stable;
    logic       w_change;
    logic       busy;

    modport master (
        output w_raw,
        input  w_stable,
        input  w_change,
        input  busy
    );

    modport slave (
        input  w_raw,
        output w_stable,
        output w_change,
        output busy
    );
endinterface

// File: rtl/switch_debouncer.sv
// -----------------------------------------------------------------------------
// switch_debouncer
// Conditions the raw 2-bit switch bus for the Moore machine: a two-flop
// synchronizer followed by a settle-time filter that commits a new 2-bit code
// only after it has been seen unchanged for DEBOUNCE_CYCLES consecutive cycles.
// Both bits are treated as one word: any movement restarts the settle time.
//
// Parameters:
//   DEBOUNCE_CYCLES : cycles a new synchronized value must hold (1..2^CNT_W)
//   CNT_W           : settle counter width (must hold DEBOUNCE_CYCLES-1)
// Ports:
//   clk   : clock shared with the Moore machine
//   reset : asynchronous assert, synchronous release, active-low
//   sw    : switch_debouncer_if.slave (w_raw in; w_stable, w_change, busy out)
// Build option:
//   SWITCH_DEBOUNCE_EN : defined   -> full settle-time filter (IDLE/SETTLE FSM)
//                        undefined -> filter compiled out; w_stable follows the
//                                     synchronized input with a fixed 3-edge
//                                     latency, w_change marks each update,
//                                     busy is always 0
// -----------------------------------------------------------------------------
module switch_debouncer #(
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned CNT_W           = 8
) (
    input  logic               clk,
    input  logic               reset,
    switch_debouncer_if.slave  sw
);

    // Illegal settle-time configurations are rejected at elaboration.
    if ((DEBOUNCE_CYCLES < 32'd1) || (DEBOUNCE_CYCLES > (32'd1 << CNT_W))) begin : g_cfg_check
        $error("switch_debouncer: DEBOUNCE_CYCLES must lie in 1..2^CNT_W");
    end

    logic [1:0] sync1_q;
    logic [1:0] sync2_q;
    logic [1:0] w_stable_q;
    logic       w_change_q;

    // Two-flop synchronizer; both bits share the same stages so a word is
    // never split across different capture cycles.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q <= 2'b00;
            sync2_q <= 2'b00;
        end else begin
            sync1_q <= sw.w_raw;
            sync2_q <= sync1_q;
        end
    end

`ifdef SWITCH_DEBOUNCE_EN

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_SETTLE = 1'b1
    } state_e;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 32'd1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(32'd1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(32'd0);

    state_e           state_q;
    state_e           state_d;
    logic [1:0]       cand_q;
    logic [1:0]       cand_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [1:0]       w_stable_d;
    logic             w_change_d;
    logic             busy_q;
    logic             busy_d;

    // Settle FSM next-state and output decode. Return-to-stable wins over a
    // candidate change, which wins over commit, so a glitch that lands back on
    // the committed code never produces a strobe.
    always_comb begin
        state_d    = state_q;
        cand_d     = cand_q;
        cnt_d      = cnt_q;
        w_stable_d = w_stable_q;
        w_change_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (sync2_q != w_stable_q) begin
                    state_d = ST_SETTLE;
                    cand_d  = sync2_q;
                    cnt_d   = CNT_ZERO;
                end else begin
                    cnt_d   = CNT_ZERO;
                end
            end
            ST_SETTLE: begin
                if (sync2_q == w_stable_q) begin
                    state_d = ST_IDLE;
                    cnt_d   = CNT_ZERO;
                end else if (sync2_q != cand_q) begin
                    cand_d  = sync2_q;
                    cnt_d   = CNT_ZERO;
                end else if (cnt_q == CNT_LAST) begin
                    w_stable_d = cand_q;
                    w_change_d = 1'b1;
                    state_d    = ST_IDLE;
                    cnt_d      = CNT_ZERO;
                end else begin
                    // Bounded by the commit compare above, so it never wraps.
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cand_d  = 2'b00;
                cnt_d   = CNT_ZERO;
            end
        endcase

        busy_d = (state_d == ST_SETTLE);
    end

    // FSM state, candidate, counter and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            cand_q     <= 2'b00;
            cnt_q      <= CNT_ZERO;
            w_stable_q <= 2'b00;
            w_change_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cand_q     <= cand_d;
            cnt_q      <= cnt_d;
            w_stable_q <= w_stable_d;
            w_change_q <= w_change_d;
            busy_q     <= busy_d;
        end
    end

    assign sw.busy = busy_q;

`else

    logic [1:0] hold_q;

    // Filter compiled out: one pipeline stage after the synchronizer keeps the
    // latency equal to the shortest debounced path (3 edges), and the strobe
    // is derived from the same register pair so it coincides with the update.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hold_q     <= 2'b00;
            w_stable_q <= 2'b00;
            w_change_q <= 1'b0;
        end else begin
            hold_q     <= sync2_q;
            w_stable_q <= hold_q;
            w_change_q <= (hold_q != w_stable_q);
        end
    end

    assign sw.busy = 1'b0;

`endif

    assign sw.w_stable = w_stable_q;
    assign sw.w_change = w_change_q;

endmodule

// File: tb/tb_switch_debouncer.sv
// -----------------------------------------------------------------------------
// tb_switch_debouncer
// Directed bench for switch_debouncer (DEBOUNCE_CYCLES=4). A run-length model
// of the debounce rule is compared against the DUT outputs on every falling
// clock edge; directed scenarios add literal expectations at chosen edges.
// Edge numbering: w_raw is changed at a falling edge, the next rising edge is
// edge 0, and the state "after edge n" is sampled at the following falling edge.
// -----------------------------------------------------------------------------
module tb_switch_debouncer;

    localparam int D = 4;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    switch_debouncer_if sw_if ();

    switch_debouncer #(
        .DEBOUNCE_CYCLES (D),
        .CNT_W           (8)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .sw    (sw_if)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // dly holds raw samples taken at past rising edges (index 0 newest).
    // A code is committed once it has been the synchronized value for D+1
    // consecutive edges while differing from the committed code.
    logic [1:0] dly [0:2];
    logic [1:0] m_stable = 2'b00;
    logic       m_change = 1'b0;
    logic       m_busy   = 1'b0;
    logic [1:0] run_val  = 2'b00;
    int         run_len  = 0;

    initial begin
        logic [1:0] s;
        dly[0] = 2'b00; dly[1] = 2'b00; dly[2] = 2'b00;
        forever begin
            @(posedge clk or negedge reset);
            if (!reset) begin
                dly[0] = 2'b00; dly[1] = 2'b00; dly[2] = 2'b00;
                m_stable = 2'b00; m_change = 1'b0; m_busy = 1'b0;
                run_val  = 2'b00; run_len  = 0;
            end else begin
`ifdef SWITCH_DEBOUNCE_EN
                s = dly[1];                 // raw value sampled two edges ago
                dly[2] = dly[1];
                dly[1] = dly[0];
                dly[0] = sw_if.w_raw;
                m_change = 1'b0;
                if (s == m_stable) begin
                    run_len = 0;
                end else if ((run_len != 0) && (s == run_val)) begin
                    run_len++;
                    if (run_len == D + 1) begin
                        m_stable = s;
                        m_change = 1'b1;
                        run_len  = 0;
                    end
                end else begin
                    run_val = s;
                    run_len = 1;
                end
                m_busy = (run_len != 0);
`else
                s = dly[2];                 // raw value sampled three edges ago
                dly[2] = dly[1];
                dly[1] = dly[0];
                dly[0] = sw_if.w_raw;
                m_change = (s != m_stable);
                m_stable = s;
                m_busy   = 1'b0;
`endif
            end
        end
    end

    // Per-cycle comparison of all outputs against the model.
    initial begin
        forever begin
            @(negedge clk);
            check("cycle", {28'd0, sw_if.w_stable, sw_if.w_change, sw_if.busy},
                           {28'd0, m_stable, m_change, m_busy});
        end
    end

    // ---------------- stimulus helpers ----------------
    int   n_chg;
    int   n_busy;
    logic saw01;

    task automatic clear_watch();
        n_chg  = 0;
        n_busy = 0;
        saw01  = 1'b0;
    endtask

    task automatic watch(input int n);
        repeat (n) begin
            @(negedge clk);
            n_chg  += int'(sw_if.w_change);
            n_busy += int'(sw_if.busy);
            if (sw_if.w_stable == 2'b01) saw01 = 1'b1;
        end
    endtask

    // Assert reset between edges and check the outputs cleared before the next edge.
    task automatic async_reset_check(input string tag);
        #2 reset = 1'b0;
        #1;
        check({tag, "_stable"}, {30'd0, sw_if.w_stable}, 32'd0);
        check({tag, "_change"}, {31'd0, sw_if.w_change}, 32'd0);
        check({tag, "_busy"},   {31'd0, sw_if.busy},     32'd0);
    endtask

    initial begin
        sw_if.w_raw = 2'b00;
        clear_watch();
        repeat (3) @(negedge clk);
        check("rst_stable", {30'd0, sw_if.w_stable}, 32'd0);
        check("rst_change", {31'd0, sw_if.w_change}, 32'd0);
        check("rst_busy",   {31'd0, sw_if.busy},     32'd0);
        reset = 1'b1;
        repeat (3) @(negedge clk);

`ifdef SWITCH_DEBOUNCE_EN
        // 00 -> 01 held: busy at edge 2, commit and strobe at edge 6
        sw_if.w_raw = 2'b01;
        repeat (2) @(negedge clk);
        check("t2_busy_e1", {31'd0, sw_if.busy}, 32'd0);
        @(negedge clk);
        check("t2_busy_e2", {31'd0, sw_if.busy}, 32'd1);
        repeat (3) @(negedge clk);
        check("t2_stable_e5", {30'd0, sw_if.w_stable}, 32'd0);
        @(negedge clk);
        check("t2_stable_e6", {30'd0, sw_if.w_stable}, 32'd1);
        check("t2_change_e6", {31'd0, sw_if.w_change}, 32'd1);
        check("t2_busy_e6",   {31'd0, sw_if.busy},     32'd0);
        @(negedge clk);
        check("t2_change_e7", {31'd0, sw_if.w_change}, 32'd0);

        // reach 10, then async reset mid-run
        clear_watch();
        sw_if.w_raw = 2'b10;
        watch(9);
        check("t1_stable_10", {30'd0, sw_if.w_stable}, 32'd2);
        check("t1_one_strobe", n_chg, 32'd1);
        async_reset_check("t1_async");
        sw_if.w_raw = 2'b00;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        // 11 for 3 cycles then back to 00: rejected glitch
        clear_watch();
        sw_if.w_raw = 2'b11;
        watch(3);
        sw_if.w_raw = 2'b00;
        watch(8);
        check("t3_busy_cycles", n_busy, 32'd3);
        check("t3_no_strobe",   n_chg,  32'd0);
        check("t3_stable",      {30'd0, sw_if.w_stable}, 32'd0);

        // 01 bouncing to 10 after 2 cycles: restart, single commit of 10 at edge 8
        clear_watch();
        sw_if.w_raw = 2'b01;
        watch(2);
        sw_if.w_raw = 2'b10;
        watch(6);
        check("t4_stable_e7", {30'd0, sw_if.w_stable}, 32'd0);
        watch(1);
        check("t4_stable_e8", {30'd0, sw_if.w_stable}, 32'd2);
        check("t4_change_e8", {31'd0, sw_if.w_change}, 32'd1);
        watch(3);
        check("t4_one_strobe", n_chg, 32'd1);
        check("t4_no_01",      {31'd0, saw01}, 32'd0);

        // single-bit move 10 -> 11 interrupted by a return to 10, then held
        clear_watch();
        sw_if.w_raw = 2'b11;
        watch(3);
        sw_if.w_raw = 2'b10;
        watch(2);
        sw_if.w_raw = 2'b11;
        watch(10);
        check("t4b_stable",     {30'd0, sw_if.w_stable}, 32'd3);
        check("t4b_one_strobe", n_chg, 32'd1);

        // reset while settling with cnt=2, released with 01 still applied
        sw_if.w_raw = 2'b01;
        repeat (5) @(negedge clk);
        check("t5_busy_pre", {31'd0, sw_if.busy}, 32'd1);
        async_reset_check("t5_async");
        clear_watch();
        watch(3);
        check("t5_no_strobe_in_reset", n_chg, 32'd0);
        reset = 1'b1;
        repeat (6) @(negedge clk);
        check("t5_stable_e5", {30'd0, sw_if.w_stable}, 32'd0);
        @(negedge clk);
        check("t5_stable_e6", {30'd0, sw_if.w_stable}, 32'd1);
        check("t5_change_e6", {31'd0, sw_if.w_change}, 32'd1);
`else
        // pass-through: 00 -> 10 appears with a strobe at edge 3
        clear_watch();
        sw_if.w_raw = 2'b10;
        repeat (3) @(negedge clk);
        check("t6_stable_e2", {30'd0, sw_if.w_stable}, 32'd0);
        @(negedge clk);
        check("t6_stable_e3", {30'd0, sw_if.w_stable}, 32'd2);
        check("t6_change_e3", {31'd0, sw_if.w_change}, 32'd1);
        @(negedge clk);
        check("t6_change_e4", {31'd0, sw_if.w_change}, 32'd0);

        // a one-cycle 01 is passed through unfiltered before 11
        clear_watch();
        sw_if.w_raw = 2'b01;
        watch(1);
        sw_if.w_raw = 2'b11;
        watch(6);
        check("t6_saw_01",   {31'd0, saw01}, 32'd1);
        check("t6_strobes",  n_chg, 32'd2);
        check("t6_stable",   {30'd0, sw_if.w_stable}, 32'd3);
        check("t6_busy_off", n_busy, 32'd0);

        async_reset_check("t6_async");
        repeat (2) @(negedge clk);
        reset = 1'b1;
        clear_watch();
        watch(6);
        check("t6_reapply", {30'd0, sw_if.w_stable}, 32'd3);
        check("t6_reapply_strobe", n_chg, 32'd1);
`endif

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
